branch_predictor_gshare: RTL and testbench

//  Next-generation fetch-stage predictor: set-associative BTB for targets plus a gshare

---
 rtl/branch_predictor_gshare.sv | 216 +++++++++++++++++++++
 tb/tb_branch_predictor_gshare.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor (PC ^ GHR indexed PHT) plus set-associative BTB, swept clear after reset.
// Optional build macro BP_PERF_CNT_EN adds lookup/hit/mispredict performance counters.
module branch_predictor_gshare #(
  parameter int unsigned ENTRIES = 512,
  parameter int unsigned WAYS    = 2,
  parameter int unsigned TAG_W   = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned GHR_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             lookup_valid_i,
  input  logic [31:0]      lookup_pc_i,
  output logic             lookup_ready_o,
  output logic             pred_valid_o,
  output logic             pred_hit_o,
  output logic             pred_taken_o,
  output logic [31:0]      pred_target_o,
  output logic [WAYS-1:0]  pred_way_o,
  output logic [CTR_W-1:0] pred_ctr_o,
  output logic [GHR_W-1:0] pred_ghr_o,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic [31:0]      upd_target_i,
  input  logic             upd_taken_i,
  input  logic [WAYS-1:0]  upd_way_i,
  input  logic [CTR_W-1:0] upd_ctr_i,
  input  logic [GHR_W-1:0] upd_ghr_i,
  input  logic             upd_mispredict_i
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]      perf_lookups_o,
  output logic [31:0]      perf_hits_o,
  output logic [31:0]      perf_mispredicts_o
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;
  localparam logic [CTR_W-1:0] CtrWeakNt = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CtrMax    = '1;

  logic [WAYS-1:0]  btb_valid_q [ENTRIES];
  logic [TAG_W-1:0] btb_tag_q   [ENTRIES][WAYS];
  logic [31:0]      btb_tgt_q   [ENTRIES][WAYS];
  logic [CTR_W-1:0] pht_q       [ENTRIES];

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [RR_W-1:0]  rr_q, rr_d;

  logic             pred_valid_q, pred_hit_q, pred_taken_q;
  logic [31:0]      pred_target_q;
  logic [WAYS-1:0]  pred_way_q;
  logic [CTR_W-1:0] pred_ctr_q;
  logic [GHR_W-1:0] pred_ghr_q;

  logic             run, accept, upd_en;
  logic [IDX_W-1:0] lk_set, lk_pht_idx, upd_set, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit;
  logic [WAYS-1:0]  lk_hit_oh, rr_oh;
  logic [31:0]      lk_tgt;
  logic [CTR_W-1:0] lk_ctr, upd_ctr_nxt;
  logic             unused_pc;

  assign unused_pc  = ^{lookup_pc_i, upd_pc_i};
  assign run        = (state_q == StRun);
  assign accept     = lookup_valid_i && run;
  assign upd_en     = upd_valid_i && run;
  assign lk_set     = lookup_pc_i[2 +: IDX_W];
  assign lk_tag     = lookup_pc_i[2+IDX_W +: TAG_W];
  assign lk_pht_idx = lk_set ^ IDX_W'(ghr_q);
  assign lk_ctr     = pht_q[lk_pht_idx];
  assign upd_set    = upd_pc_i[2 +: IDX_W];
  assign upd_tag    = upd_pc_i[2+IDX_W +: TAG_W];
  assign upd_idx    = upd_set ^ IDX_W'(upd_ghr_i);

  // Scan from the top way down so the lowest matching way wins.
  always_comb begin
    lk_hit    = 1'b0;
    lk_hit_oh = '0;
    lk_tgt    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (btb_valid_q[lk_set][w] && (btb_tag_q[lk_set][w] == lk_tag)) begin
        lk_hit        = 1'b1;
        lk_hit_oh     = '0;
        lk_hit_oh[w]  = 1'b1;
        lk_tgt        = btb_tgt_q[lk_set][w];
      end
    end
  end

  always_comb begin
    rr_oh        = '0;
    rr_oh[rr_q]  = 1'b1;
  end

  always_comb begin
    if (upd_taken_i) begin
      upd_ctr_nxt = (upd_ctr_i == CtrMax) ? upd_ctr_i : upd_ctr_i + CTR_W'(1);
    end else begin
      upd_ctr_nxt = (upd_ctr_i == '0) ? upd_ctr_i : upd_ctr_i - CTR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == StInit) begin
      sweep_d = sweep_q + IDX_W'(1);
      if (sweep_q == IDX_W'(ENTRIES - 1)) begin
        state_d = StRun;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (accept && !lk_hit && (WAYS > 1)) begin
      rr_d = (rr_q == RR_W'(WAYS - 1)) ? '0 : rr_q + RR_W'(1);
    end
  end

  // Mispredict recovery takes priority over the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_en && upd_mispredict_i) begin
      ghr_d = {upd_ghr_i[GHR_W-2:0], upd_taken_i};
    end else if (pred_valid_q && pred_hit_q) begin
      ghr_d = {ghr_q[GHR_W-2:0], pred_taken_q};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StInit;
      sweep_q       <= '0;
      ghr_q         <= '0;
      rr_q          <= '0;
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_way_q    <= '0;
      pred_ctr_q    <= '0;
      pred_ghr_q    <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      ghr_q        <= ghr_d;
      rr_q         <= rr_d;
      pred_valid_q <= accept;
      if (accept) begin
        pred_hit_q    <= lk_hit;
        pred_taken_q  <= lk_hit && lk_ctr[CTR_W-1];
        pred_target_q <= lk_tgt;
        pred_way_q    <= lk_hit ? lk_hit_oh : rr_oh;
        pred_ctr_q    <= lk_ctr;
        pred_ghr_q    <= ghr_q;
      end
    end
  end

  // Tables are not reset; the INIT sweep clears them. Reads above are read-first.
  always_ff @(posedge clk_i) begin
    if (state_q == StInit) begin
      btb_valid_q[sweep_q] <= '0;
      pht_q[sweep_q]       <= CtrWeakNt;
    end else if (upd_en) begin
      pht_q[upd_idx] <= upd_ctr_nxt;
      if (upd_taken_i) begin
        for (int w = 0; w < WAYS; w++) begin
          if (upd_way_i[w]) begin
            btb_valid_q[upd_set][w] <= 1'b1;
            btb_tag_q[upd_set][w]   <= upd_tag;
            btb_tgt_q[upd_set][w]   <= upd_target_i;
          end
        end
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_lookups_q, perf_hits_q, perf_mispredicts_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_lookups_q     <= '0;
      perf_hits_q        <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      if (accept)                      perf_lookups_q     <= perf_lookups_q + 32'd1;
      if (pred_valid_q && pred_hit_q)  perf_hits_q        <= perf_hits_q + 32'd1;
      if (upd_en && upd_mispredict_i)  perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
    end
  end

  assign perf_lookups_o     = perf_lookups_q;
  assign perf_hits_o        = perf_hits_q;
  assign perf_mispredicts_o = perf_mispredicts_q;
`endif

  assign lookup_ready_o = run;
  assign pred_valid_o   = pred_valid_q;
  assign pred_hit_o     = pred_hit_q;
  assign pred_taken_o   = pred_taken_q;
  assign pred_target_o  = pred_target_q;
  assign pred_way_o     = pred_way_q;
  assign pred_ctr_o     = pred_ctr_q;
  assign pred_ghr_o     = pred_ghr_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for branch_predictor_gshare: directed scenarios then random traffic against an array-based model.
module tb_branch_predictor_gshare;
  localparam int ENTRIES = 512;
  localparam int WAYS    = 2;
  localparam int TAG_W   = 16;
  localparam int CTR_W   = 2;
  localparam int GHR_W   = 8;
  localparam int IDX_W   = 9;
  localparam int CTR_MAX = (1 << CTR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             lv = 1'b0;
  logic [31:0]      lpc = '0;
  logic             uv = 1'b0;
  logic [31:0]      upc = '0;
  logic [31:0]      utgt = '0;
  logic             ut = 1'b0;
  logic [WAYS-1:0]  uway = '0;
  logic [CTR_W-1:0] uctr = '0;
  logic [GHR_W-1:0] ughr = '0;
  logic             umis = 1'b0;

  logic             lookup_ready_o, pred_valid_o, pred_hit_o, pred_taken_o;
  logic [31:0]      pred_target_o;
  logic [WAYS-1:0]  pred_way_o;
  logic [CTR_W-1:0] pred_ctr_o;
  logic [GHR_W-1:0] pred_ghr_o;

  branch_predictor_gshare dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .lookup_valid_i   (lv),
    .lookup_pc_i      (lpc),
    .lookup_ready_o   (lookup_ready_o),
    .pred_valid_o     (pred_valid_o),
    .pred_hit_o       (pred_hit_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .pred_way_o       (pred_way_o),
    .pred_ctr_o       (pred_ctr_o),
    .pred_ghr_o       (pred_ghr_o),
    .upd_valid_i      (uv),
    .upd_pc_i         (upc),
    .upd_target_i     (utgt),
    .upd_taken_i      (ut),
    .upd_way_i        (uway),
    .upd_ctr_i        (uctr),
    .upd_ghr_i        (ughr),
    .upd_mispredict_i (umis)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain arrays for BTB/PHT, integers for history and victim pointer.
  bit          mv   [ENTRIES][WAYS];
  int          mtag [ENTRIES][WAYS];
  int unsigned mtgt [ENTRIES][WAYS];
  int          mpht [ENTRIES];
  int          ghr, rr;
  bit          e_valid, e_hit, e_taken;
  int unsigned e_tgt;
  int          e_way, e_ctr, e_ghr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int set_of(input int unsigned pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int tag_of(input int unsigned pc);
    return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
  endfunction

  task automatic model_reset_tables();
    for (int s = 0; s < ENTRIES; s++) begin
      mpht[s] = (1 << (CTR_W - 1)) - 1;
      for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
    end
    ghr = 0;
    rr = 0;
    e_valid = 1'b0;
    e_hit = 1'b0;
    e_taken = 1'b0;
  endtask

  task automatic model_edge();
    bit prev_hit, prev_taken;
    int s, t, hw, i;
    prev_hit   = e_valid && e_hit;
    prev_taken = e_taken;
    if (lv) begin
      s = set_of(lpc);
      t = tag_of(lpc);
      hw = -1;
      for (int w = 0; w < WAYS; w++)
        if (hw < 0 && mv[s][w] && mtag[s][w] == t) hw = w;
      e_valid = 1'b1;
      e_hit   = (hw >= 0);
      e_ghr   = ghr;
      e_ctr   = mpht[s ^ ghr];
      e_taken = e_hit && (e_ctr >= (1 << (CTR_W - 1)));
      if (e_hit) begin
        e_tgt = mtgt[s][hw];
        e_way = 1 << hw;
      end else begin
        e_tgt = 0;
        e_way = 1 << rr;
        rr = (rr + 1) % WAYS;
      end
    end else begin
      e_valid = 1'b0;
    end
    if (uv && umis) ghr = ((int'(ughr) << 1) | int'(ut)) % (1 << GHR_W);
    else if (prev_hit) ghr = ((ghr << 1) | int'(prev_taken)) % (1 << GHR_W);
    if (uv) begin
      i = set_of(upc) ^ int'(ughr);
      if (ut) mpht[i] = (int'(uctr) + 1 > CTR_MAX) ? CTR_MAX : int'(uctr) + 1;
      else    mpht[i] = (int'(uctr) == 0) ? 0 : int'(uctr) - 1;
      if (ut) begin
        for (int w = 0; w < WAYS; w++) begin
          if (uway[w]) begin
            mv[set_of(upc)][w]   = 1'b1;
            mtag[set_of(upc)][w] = tag_of(upc);
            mtgt[set_of(upc)][w] = utgt;
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("pred_valid", pred_valid_o, e_valid);
    if (e_valid) begin
      chk("pred_hit", pred_hit_o, e_hit);
      chk("pred_taken", pred_taken_o, e_taken);
      chk("pred_target", pred_target_o, e_tgt);
      chk("pred_way", pred_way_o, e_way);
      chk("pred_ctr", pred_ctr_o, e_ctr);
      chk("pred_ghr", pred_ghr_o, e_ghr);
    end
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lv = 1'b1; lpc = pc; uv = 1'b0;
    tick();
    lv = 1'b0;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                        input logic [WAYS-1:0] way, input int ctr, input int gh, input logic mis);
    lv = 1'b0; uv = 1'b1; upc = pc; utgt = tgt; ut = taken; uway = way;
    uctr = CTR_W'(ctr); ughr = GHR_W'(gh); umis = mis;
    tick();
    uv = 1'b0; umis = 1'b0;
  endtask

  // Force GHR to zero via a recovery whose PHT side-effect lands in set 1.
  task automatic clear_ghr();
    do_upd(32'h7004, 32'h0, 1'b0, 2'b01, 1, 0, 1'b1);
  endtask

  initial begin
    int n;
    bit pv_seen;
    int w6;
    int unsigned tgts [3];
    logic [31:0] pcs [3];

    // 1: reset values, then INIT sweep length with a mid-sweep reset
    lv = 1'b1; lpc = 32'h1000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", lookup_ready_o, 0);
    chk("rst_pred_valid", pred_valid_o, 0);
    chk("rst_pred_hit", pred_hit_o, 0);
    chk("rst_pred_target", pred_target_o, 0);
    chk("rst_pred_way", pred_way_o, 0);
    chk("rst_pred_ctr", pred_ctr_o, 0);
    chk("rst_pred_ghr", pred_ghr_o, 0);
    rst = 1'b0;
    pv_seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      pv_seen |= (pred_valid_o !== 1'b0);
    end
    chk("sweep100_ready", lookup_ready_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (lookup_ready_o !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      pv_seen |= (pred_valid_o !== 1'b0);
    end
    lv = 1'b0;
    chk("init_len", n, ENTRIES);
    chk("init_pred_valid_seen", pv_seen, 0);
    model_reset_tables();

    // 2: cold lookup misses with weakly-not-taken counter
    do_lookup(32'h1000);
    chk("t2_hit", pred_hit_o, 0);
    chk("t2_ctr", pred_ctr_o, 1);
    chk("t2_taken", pred_taken_o, 0);
    chk("t2_target", pred_target_o, 0);

    // 3: taken update allocates; re-lookup hits and predicts taken
    do_upd(32'h1000, 32'h2000, 1'b1, 2'b01, 1, 0, 1'b0);
    do_lookup(32'h1000);
    chk("t3_hit", pred_hit_o, 1);
    chk("t3_ctr", pred_ctr_o, 2);
    chk("t3_taken", pred_taken_o, 1);
    chk("t3_target", pred_target_o, 32'h2000);

    // 4: saturation both ways
    clear_ghr();
    repeat (4) do_upd(32'h1000, 32'h2000, 1'b1, 2'b01, mpht[0], 0, 1'b0);
    do_lookup(32'h1000);
    chk("t4_ctr_sat_hi", pred_ctr_o, 3);
    clear_ghr();
    repeat (4) do_upd(32'h1000, 32'h2000, 1'b0, 2'b01, mpht[0], 0, 1'b0);
    do_lookup(32'h1000);
    chk("t4_ctr_sat_lo", pred_ctr_o, 0);
    chk("t4_taken", pred_taken_o, 0);

    // 5: recovery wins over same-cycle speculative shift
    do_upd(32'h7004, 32'h0, 1'b0, 2'b01, 1, 8'h2D, 1'b1);
    do_lookup(32'h1000);
    chk("t5_ghr_5a", pred_ghr_o, 8'h5A);
    chk("t5_hit", pred_hit_o, 1);
    do_upd(32'h5008, 32'h6000, 1'b1, 2'b10, 1, 8'h33, 1'b1);
    do_lookup(32'h1000);
    chk("t5_ghr_67", pred_ghr_o, 8'h67);

    // 6: three taken branches in one set evict the first
    pcs[0] = 32'h8100; pcs[1] = 32'h10100; pcs[2] = 32'h18100;
    tgts[0] = 32'hA000; tgts[1] = 32'hB000; tgts[2] = 32'hC000;
    for (int k = 0; k < 3; k++) begin
      do_lookup(pcs[k]);
      w6 = e_way;
      do_upd(pcs[k], tgts[k], 1'b1, WAYS'(w6), e_ctr, e_ghr, 1'b0);
    end
    do_lookup(pcs[0]);
    chk("t6_first_evicted", pred_hit_o, 0);
    do_lookup(pcs[2]);
    chk("t6_third_hit", pred_hit_o, 1);
    chk("t6_third_target", pred_target_o, 32'hC000);
    do_lookup(pcs[1]);
    chk("t6_second_hit", pred_hit_o, 1);

    // Random traffic on a small PC pool so sets collide and entries get reused
    for (int c = 0; c < 1500; c++) begin
      lv   = ($urandom_range(0, 9) < 6);
      lpc  = 32'h400 | (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 2);
      uv   = ($urandom_range(0, 1) == 1);
      upc  = 32'h400 | (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 2);
      utgt = $urandom & 32'hFFFF_FFFC;
      ut   = $urandom_range(0, 1) == 1;
      uway = WAYS'(1 << $urandom_range(0, WAYS - 1));
      uctr = CTR_W'($urandom_range(0, CTR_MAX));
      ughr = GHR_W'($urandom_range(0, 255));
      umis = ($urandom_range(0, 3) == 0);
      tick();
    end
    lv = 1'b0; uv = 1'b0; umis = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
